prog_launcher: RTL and testbench
================================

Name: prog_launcher

Overview:
- Control-side driver for the program counter.
- Issues the Start pulse and the initial absolute branch that select which stored program runs.
- Times the run and reports completion or timeout to the top-level harness.
- Sits between the external test/host handshake and the program counter's Start/BranchAbsEn/Target inputs.

Parameters:
- PC_W, 10, program counter / target width.
- CNT_W, 16, cycle counter width.
- PROG0_ADDR, 0, start address of program 0.
- PROG1_ADDR, 128, start address of program 1.
- PROG2_ADDR, 256, start address of program 2.
- PROG3_ADDR, 384, start address of program 3.
- TIMEOUT, 4000, maximum RUN cycles before forced stop; must be < 2**CNT_W.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Go  in  1  launch request; sampled only in IDLE.
- ProgSel  in  2  program index, captured on an accepted Go.
- Done  in  1  halt indication from the decoder; sampled only in RUN.
- ProgCtr  in  PC_W  current program counter value, used for status capture.
- Start  out  1  Start pulse to the program counter.
- BranchAbsEn  out  1  absolute branch enable to the program counter.
- Target  out  PC_W  branch target to the program counter.
- Busy  out  1  high in every state except IDLE.
- Ack  out  1  one-cycle completion pulse.
- TimedOut  out  1  qualifies Ack; holds until the next accepted Go.
- CycleCount  out  CNT_W  RUN cycles of the last or current run.
- LastPC  out  PC_W  ProgCtr value captured at run end.

Behaviour:
- Reset asserted (low, asynchronous):
  - state = IDLE.
  - All outputs are 0; Target = 0.
  - Internal Sel register = 0.
  - Takes effect immediately, including mid-run; no Ack is produced for an aborted run.
- States: IDLE, START, JUMP, RUN, FIN.
- IDLE:
  - Go=1 → capture Sel<=ProgSel, clear CycleCount, clear TimedOut, go to START.
  - Go=0 → stay.
- START: Start=1 for exactly this cycle → JUMP.
- JUMP:
  - BranchAbsEn=1 for exactly this cycle.
  - Target = PROGn_ADDR selected by Sel.
  - → RUN.
- RUN:
  - CycleCount increments by 1 every cycle.
  - Done=1 → capture LastPC<=ProgCtr, → FIN.
  - If Done=0 and CycleCount == TIMEOUT-1 on this edge → TimedOut<=1, capture LastPC, → FIN.
  - Done=1 on the same cycle as the timeout condition: Done wins, TimedOut stays 0.
  - The cycle in which the exit condition is detected is counted: Done seen in the first RUN cycle gives CycleCount=1.
- FIN: Ack=1 for this cycle only → IDLE.
- Target outside JUMP: holds the last driven value; 0 after reset.
- Start and BranchAbsEn are never high in the same cycle.
- Busy is combinational from state.
- Latency: Go accepted at edge N gives:
  - Start high during cycle N+1.
  - BranchAbsEn high during cycle N+2.
  - First RUN cycle N+3.
- Go is ignored in every state except IDLE; there is no queuing.
- Go held high continuously: relaunches on the cycle after FIN returns to IDLE, i.e. one IDLE cycle between runs.
- Done outside RUN is ignored.
- CycleCount never wraps; TIMEOUT < 2**CNT_W guarantees this.
- CycleCount, LastPC, Sel and TimedOut hold their values in IDLE until the next accepted Go.
- Target must be valid the same cycle BranchAbsEn is high; drive it from a register loaded on the START→JUMP transition.

Test Plan:
- Reset low mid-RUN (Sel=2, CycleCount=5) → immediately state IDLE, all outputs 0; after release no Ack appears, Busy=0.
- Go=1 with ProgSel=1 for one cycle at edge N → Start=1 only in cycle N+1; BranchAbsEn=1 with Target=128 only in cycle N+2; Busy=1 from N+1.
- Run with Done asserted in the 7th RUN cycle while ProgCtr=135 → Ack one cycle later; CycleCount=7, LastPC=135, TimedOut=0, Busy=0 the cycle after Ack.
- Done held 0 with TIMEOUT=4000 → FIN after exactly 4000 RUN cycles; TimedOut=1, CycleCount=4000, Ack pulse.
- Go toggled during START/JUMP/RUN, and Done pulsed during START/JUMP → no effect on state, counts or Ack.
- Go held high across two runs with ProgSel 3 then 0 → second Start one IDLE cycle after the first Ack; Targets 384 then 0; TimedOut cleared at the second launch.

Source files
------------

// File: rtl/prog_launcher.sv
// Launch sequencer for the program counter: Start pulse, absolute branch to the
// selected program, then times the run and reports completion or timeout.
module prog_launcher #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PROG0_ADDR = 0,
    parameter int unsigned PROG1_ADDR = 128,
    parameter int unsigned PROG2_ADDR = 256,
    parameter int unsigned PROG3_ADDR = 384,
    parameter int unsigned TIMEOUT    = 4000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic [1:0]       ProgSel,
    input  logic             Done,
    input  logic [PC_W-1:0]  ProgCtr,
    output logic             Start,
    output logic             BranchAbsEn,
    output logic [PC_W-1:0]  Target,
    output logic             Busy,
    output logic             Ack,
    output logic             TimedOut,
    output logic [CNT_W-1:0] CycleCount,
    output logic [PC_W-1:0]  LastPC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_JUMP,
        S_RUN,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out_q, timed_out_d;
    logic [PC_W-1:0]  prog_addr;

    always_comb begin
        case (sel_q)
            2'd0:    prog_addr = PC_W'(PROG0_ADDR);
            2'd1:    prog_addr = PC_W'(PROG1_ADDR);
            2'd2:    prog_addr = PC_W'(PROG2_ADDR);
            default: prog_addr = PC_W'(PROG3_ADDR);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        target_d    = target_q;
        last_pc_d   = last_pc_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    sel_d       = ProgSel;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                // Target is registered so it is stable for the whole JUMP cycle.
                target_d = prog_addr;
                state_d  = S_JUMP;
            end
            S_JUMP: state_d = S_RUN;
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (Done) begin
                    last_pc_d = ProgCtr;
                    state_d   = S_FIN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timed_out_d = 1'b1;
                    last_pc_d   = ProgCtr;
                    state_d     = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            target_q    <= '0;
            last_pc_q   <= '0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            target_q    <= target_d;
            last_pc_q   <= last_pc_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign Start       = (state_q == S_START);
    assign BranchAbsEn = (state_q == S_JUMP);
    assign Busy        = (state_q != S_IDLE);
    assign Ack         = (state_q == S_FIN);
    assign Target      = target_q;
    assign TimedOut    = timed_out_q;
    assign CycleCount  = cnt_q;
    assign LastPC      = last_pc_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: launch timing, completion, timeout and
// its Done-wins corner, ignored inputs, back-to-back runs and async reset.
module tb_prog_launcher;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             go;
    logic [1:0]       prog_sel;
    logic             done;
    logic [PC_W-1:0]  prog_ctr;
    logic             start;
    logic             branch_abs_en;
    logic [PC_W-1:0]  target;
    logic             busy;
    logic             ack;
    logic             timed_out;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  last_pc;

    int unsigned n_tests;
    int unsigned n_fail;

    prog_launcher #(
        .PC_W       (PC_W),
        .CNT_W      (CNT_W),
        .PROG0_ADDR (0),
        .PROG1_ADDR (128),
        .PROG2_ADDR (256),
        .PROG3_ADDR (384),
        .TIMEOUT    (4000)
    ) dut (
        .Clk         (clk),
        .Reset       (rst_n),
        .Go          (go),
        .ProgSel     (prog_sel),
        .Done        (done),
        .ProgCtr     (prog_ctr),
        .Start       (start),
        .BranchAbsEn (branch_abs_en),
        .Target      (target),
        .Busy        (busy),
        .Ack         (ack),
        .TimedOut    (timed_out),
        .CycleCount  (cycle_count),
        .LastPC      (last_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Drive Go for one accepted edge, then leave the run in its first RUN cycle.
    task automatic launch_to_run(input logic [1:0] sel);
        go = 1'b1;
        prog_sel = sel;
        tick();
        go = 1'b0;
        tick(2);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        go       = 1'b0;
        prog_sel = 2'd0;
        done     = 1'b0;
        prog_ctr = '0;

        // Reset state
        #12;
        check_eq("rst_busy",   32'(busy), 0);
        check_eq("rst_start",  32'(start), 0);
        check_eq("rst_bae",    32'(branch_abs_en), 0);
        check_eq("rst_ack",    32'(ack), 0);
        check_eq("rst_to",     32'(timed_out), 0);
        check_eq("rst_cnt",    32'(cycle_count), 0);
        check_eq("rst_lastpc", 32'(last_pc), 0);
        check_eq("rst_target", 32'(target), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        check_eq("idle_busy", 32'(busy), 0);

        // Launch latency with ProgSel=1
        go = 1'b1;
        prog_sel = 2'd1;
        tick();
        go = 1'b0;
        check_eq("n1_start", 32'(start), 1);
        check_eq("n1_bae",   32'(branch_abs_en), 0);
        check_eq("n1_busy",  32'(busy), 1);
        tick();
        check_eq("n2_start",  32'(start), 0);
        check_eq("n2_bae",    32'(branch_abs_en), 1);
        check_eq("n2_target", 32'(target), 128);
        tick();
        check_eq("n3_bae",    32'(branch_abs_en), 0);
        check_eq("n3_target", 32'(target), 128);
        check_eq("n3_busy",   32'(busy), 1);

        // Done in the 7th RUN cycle
        prog_ctr = 10'd130;
        tick(6);
        check_eq("run7_ack", 32'(ack), 0);
        done = 1'b1;
        prog_ctr = 10'd135;
        tick();
        done = 1'b0;
        check_eq("fin_ack",    32'(ack), 1);
        check_eq("fin_cnt",    32'(cycle_count), 7);
        check_eq("fin_lastpc", 32'(last_pc), 135);
        check_eq("fin_to",     32'(timed_out), 0);
        tick();
        check_eq("post_ack",  32'(ack), 0);
        check_eq("post_busy", 32'(busy), 0);
        check_eq("hold_cnt",  32'(cycle_count), 7);

        // Go/Done during START/JUMP/RUN are ignored
        go = 1'b1;
        prog_sel = 2'd2;
        tick();
        done = 1'b1;
        prog_sel = 2'd3;
        tick();
        check_eq("ign_jump_bae", 32'(branch_abs_en), 1);
        check_eq("ign_target",   32'(target), 256);
        go = 1'b0;
        tick();
        check_eq("ign_run_busy", 32'(busy), 1);
        check_eq("ign_run_ack",  32'(ack), 0);
        check_eq("ign_run_cnt",  32'(cycle_count), 0);
        done = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        check_eq("ign_run4_start", 32'(start), 0);
        check_eq("ign_run4_ack",   32'(ack), 0);
        go = 1'b0;
        done = 1'b1;
        prog_ctr = 10'd260;
        tick();
        done = 1'b0;
        check_eq("ign_fin_ack",    32'(ack), 1);
        check_eq("ign_fin_cnt",    32'(cycle_count), 4);
        check_eq("ign_fin_lastpc", 32'(last_pc), 260);
        tick();
        check_eq("ign_idle_busy", 32'(busy), 0);

        // Timeout after exactly 4000 RUN cycles
        launch_to_run(2'd0);
        prog_ctr = 10'd77;
        tick(3999);
        check_eq("to_pre_ack", 32'(ack), 0);
        check_eq("to_pre_cnt", 32'(cycle_count), 3999);
        tick();
        check_eq("to_ack",    32'(ack), 1);
        check_eq("to_flag",   32'(timed_out), 1);
        check_eq("to_cnt",    32'(cycle_count), 4000);
        check_eq("to_lastpc", 32'(last_pc), 77);
        tick();
        check_eq("to_idle_busy", 32'(busy), 0);
        check_eq("to_hold",      32'(timed_out), 1);

        // Go held across two runs: ProgSel 3 then 0
        go = 1'b1;
        prog_sel = 2'd3;
        tick();
        check_eq("b2b_start1", 32'(start), 1);
        check_eq("b2b_to_clr", 32'(timed_out), 0);
        prog_sel = 2'd0;
        tick();
        check_eq("b2b_target1", 32'(target), 384);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_eq("b2b_ack1", 32'(ack), 1);
        check_eq("b2b_cnt1", 32'(cycle_count), 1);
        tick();
        check_eq("b2b_idle_busy",  32'(busy), 0);
        check_eq("b2b_idle_start", 32'(start), 0);
        tick();
        check_eq("b2b_start2", 32'(start), 1);
        go = 1'b0;
        tick();
        check_eq("b2b_bae2",    32'(branch_abs_en), 1);
        check_eq("b2b_target2", 32'(target), 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check_eq("b2b_ack2", 32'(ack), 1);
        tick();

        // Done coincides with the timeout condition: Done wins
        launch_to_run(2'd1);
        prog_ctr = 10'd50;
        tick(3999);
        done = 1'b1;
        prog_ctr = 10'd99;
        tick();
        done = 1'b0;
        check_eq("dw_ack",    32'(ack), 1);
        check_eq("dw_to",     32'(timed_out), 0);
        check_eq("dw_cnt",    32'(cycle_count), 4000);
        check_eq("dw_lastpc", 32'(last_pc), 99);
        tick();

        // Asynchronous reset mid-RUN (Sel=2, CycleCount=5)
        launch_to_run(2'd2);
        tick(5);
        check_eq("mr_cnt_pre", 32'(cycle_count), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_busy",   32'(busy), 0);
        check_eq("mr_cnt",    32'(cycle_count), 0);
        check_eq("mr_target", 32'(target), 0);
        check_eq("mr_lastpc", 32'(last_pc), 0);
        check_eq("mr_ack",    32'(ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mr_post_ack",  32'(ack), 0);
            check_eq("mr_post_busy", 32'(busy), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
